// File: rtl/prio_heap_if.sv
// -----------------------------------------------------------------------------
// prio_heap_if : command/result bundle of the prio_heap priority queue.
//
// Parameters KEY_BITS / TAG_BITS / DEPTH_LOG must match the attached prio_heap.
//
// Signals (direction seen from the heap, i.e. the slave modport):
//   cmd      in   2            0 NOOP, 1 PUSH, 2 POP, 3 REPLACE
//   din      in   KEY_BITS     key for PUSH/REPLACE
//   din_tag  in   TAG_BITS     payload for PUSH/REPLACE
//   check    in   1            start a heap-property scan (HEAP_CHECK_EN builds)
//   dout     out  KEY_BITS     current minimum key, 0 when empty
//   dout_tag out  TAG_BITS     payload of the minimum, 0 when empty
//   ready    out  1            heap idle, command will be sampled
//   full     out  1            count == capacity
//   empty    out  1            count == 0
//   count    out  DEPTH_LOG+1  occupancy
//   reject   out  1            one-cycle pulse for an illegal command
//   error    out  1            sticky heap-violation flag
// -----------------------------------------------------------------------------
interface prio_heap_if #(
    parameter int KEY_BITS  = 4,
    parameter int TAG_BITS  = 4,
    parameter int DEPTH_LOG = 3
);
    logic [1:0]           cmd;
    logic [KEY_BITS-1:0]  din;
    logic [TAG_BITS-1:0]  din_tag;
    logic                 check;
    logic [KEY_BITS-1:0]  dout;
    logic [TAG_BITS-1:0]  dout_tag;
    logic                 ready;
    logic                 full;
    logic                 empty;
    logic [DEPTH_LOG:0]   count;
    logic                 reject;
    logic                 error;

    modport master (
        output cmd, din, din_tag, check,
        input  dout, dout_tag, ready, full, empty, count, reject, error
    );

    modport slave (
        input  cmd, din, din_tag, check,
        output dout, dout_tag, ready, full, empty, count, reject, error
    );
endinterface

// File: rtl/prio_heap.sv
// -----------------------------------------------------------------------------
// prio_heap : min-heap priority queue of 2**DEPTH_LOG {key, tag} entries.
// Smaller key = higher priority; the tag rides along and is never compared.
// Commands PUSH, POP and REPLACE (pop-min + push) are accepted only while
// ready; each walks the heap with at most one array read per cycle.
//
// Ports:
//   clock_i  in  1   single clock, rising edge
//   reset_i  in  1   synchronous, active-high; abandons any operation
//   bus      slave modport of prio_heap_if (command inputs, status outputs)
//
// Optional feature: define HEAP_CHECK_EN to add the heap-property scan
// (check input, sticky error output). Without it check is ignored and
// error is tied low.
// -----------------------------------------------------------------------------
module prio_heap #(
    parameter int KEY_BITS  = 4,
    parameter int TAG_BITS  = 4,
    parameter int DEPTH_LOG = 3
) (
    input  logic        clock_i,
    input  logic        reset_i,
    prio_heap_if.slave  bus
);
    localparam int WORDS = 1 << DEPTH_LOG;
    localparam int EW    = KEY_BITS + TAG_BITS;
    localparam int AW    = DEPTH_LOG;
    // Two spare index bits so child indices past the array still compare large.
    localparam int IW    = DEPTH_LOG + 2;

    localparam logic [1:0]         CMD_NOOP    = 2'd0;
    localparam logic [1:0]         CMD_PUSH    = 2'd1;
    localparam logic [1:0]         CMD_POP     = 2'd2;
    localparam logic [1:0]         CMD_REPLACE = 2'd3;
    localparam logic [DEPTH_LOG:0] FULL_CNT    = (DEPTH_LOG+1)'(WORDS);
    localparam logic [DEPTH_LOG:0] CNT_ONE     = (DEPTH_LOG+1)'(1);
    localparam logic [IW-1:0]      IDX_ONE     = IW'(1);
    localparam logic [AW-1:0]      ADDR_ONE    = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PUSH_RD  = 3'd1,
        S_PUSH_CMP = 3'd2,
        S_POP_RDL  = 3'd3,
        S_POP_RDR  = 3'd4,
        S_POP_CMP  = 3'd5
`ifdef HEAP_CHECK_EN
        ,
        S_CHK_RD   = 3'd6,
        S_CHK_CMP  = 3'd7
`endif
    } state_t;

    function automatic logic [KEY_BITS-1:0] key_of(input logic [EW-1:0] e);
        return e[EW-1:TAG_BITS];
    endfunction

    state_t              state_q, state_d;
    logic [DEPTH_LOG:0]  count_q, count_d;
    logic [IW-1:0]       posn_q, posn_d;
    logic [EW-1:0]       h0_q, h0_d;     // entry being sifted
    logic [EW-1:0]       h1_q, h1_d;     // parent / left child
    logic [EW-1:0]       h2_q, h2_d;     // right child
    logic                reject_q, reject_d;
    logic [EW-1:0]       h_q [WORDS];

    logic                wr_en_s;
    logic [AW-1:0]       wr_addr_s;
    logic [EW-1:0]       wr_data_s;
    logic [AW-1:0]       rd_addr_s;
    logic [EW-1:0]       rd_data_s;
    logic [IW-1:0]       parent_s, left_s, right_s, count_ext_s, child_idx_s;
    logic                left_ok_s, right_ok_s, take_left_s, have_child_s;
    logic [EW-1:0]       child_s;

`ifdef HEAP_CHECK_EN
    logic                error_q, error_d;
`else
    logic                unused_check_s;
    assign unused_check_s = bus.check;
`endif

    assign parent_s    = (posn_q - IDX_ONE) >> 1;
    assign left_s      = {posn_q[IW-2:0], 1'b0} + IDX_ONE;
    assign right_s     = left_s + IDX_ONE;
    assign count_ext_s = {1'b0, count_q};

    // A child exists only below the (already decremented) occupancy.
    assign left_ok_s    = left_s < count_ext_s;
    assign right_ok_s   = right_s < count_ext_s;
    assign take_left_s  = left_ok_s && (!right_ok_s || (key_of(h1_q) <= key_of(h2_q)));
    assign have_child_s = left_ok_s || right_ok_s;
    assign child_s      = take_left_s ? h1_q : h2_q;
    assign child_idx_s  = take_left_s ? left_s : right_s;

    assign rd_data_s = h_q[rd_addr_s];

    // Single array read address, chosen by the current state only.
    always_comb begin
        rd_addr_s = {AW{1'b0}};
        case (state_q)
            S_IDLE:    rd_addr_s = count_q[AW-1:0] - ADDR_ONE;  // last entry for POP
            S_PUSH_RD: rd_addr_s = parent_s[AW-1:0];
            S_POP_RDL: rd_addr_s = left_s[AW-1:0];
            S_POP_RDR: rd_addr_s = right_s[AW-1:0];
`ifdef HEAP_CHECK_EN
            S_CHK_RD:  rd_addr_s = parent_s[AW-1:0];
            S_CHK_CMP: rd_addr_s = posn_q[AW-1:0];
`endif
            default:   rd_addr_s = {AW{1'b0}};
        endcase
    end

    // Next-state, datapath and array-write decisions.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        posn_d    = posn_q;
        h0_d      = h0_q;
        h1_d      = h1_q;
        h2_d      = h2_q;
        reject_d  = 1'b0;
        wr_en_s   = 1'b0;
        wr_addr_s = posn_q[AW-1:0];
        wr_data_s = h0_q;
`ifdef HEAP_CHECK_EN
        error_d   = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                case (bus.cmd)
                    CMD_PUSH: begin
                        if (count_q == FULL_CNT) begin
                            reject_d = 1'b1;
                        end else begin
                            posn_d  = {1'b0, count_q};
                            h0_d    = {bus.din, bus.din_tag};
                            count_d = count_q + CNT_ONE;
                            state_d = S_PUSH_RD;
                        end
                    end
                    CMD_POP: begin
                        if (count_q == {(DEPTH_LOG+1){1'b0}}) begin
                            reject_d = 1'b1;
                        end else begin
                            // Move the last entry to the root, then sift it down.
                            count_d   = count_q - CNT_ONE;
                            h0_d      = rd_data_s;
                            wr_en_s   = 1'b1;
                            wr_addr_s = {AW{1'b0}};
                            wr_data_s = rd_data_s;
                            posn_d    = {IW{1'b0}};
                            state_d   = S_POP_RDL;
                        end
                    end
                    CMD_REPLACE: begin
                        if (count_q == {(DEPTH_LOG+1){1'b0}}) begin
                            reject_d = 1'b1;
                        end else begin
                            h0_d      = {bus.din, bus.din_tag};
                            wr_en_s   = 1'b1;
                            wr_addr_s = {AW{1'b0}};
                            wr_data_s = {bus.din, bus.din_tag};
                            posn_d    = {IW{1'b0}};
                            state_d   = S_POP_RDL;
                        end
                    end
                    CMD_NOOP: begin
`ifdef HEAP_CHECK_EN
                        if (bus.check) begin
                            error_d = 1'b0;
                            posn_d  = IDX_ONE;
                            state_d = S_CHK_RD;
                        end else begin
                            state_d = S_IDLE;
                        end
`else
                        state_d = S_IDLE;
`endif
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_PUSH_RD: begin
                h1_d    = rd_data_s;
                state_d = S_PUSH_CMP;
            end
            S_PUSH_CMP: begin
                wr_en_s = 1'b1;
                // Equal keys stop the climb, keeping insertion order stable-ish.
                if ((posn_q == {IW{1'b0}}) || (key_of(h1_q) <= key_of(h0_q))) begin
                    wr_data_s = h0_q;
                    state_d   = S_IDLE;
                end else begin
                    wr_data_s = h1_q;
                    posn_d    = parent_s;
                    state_d   = S_PUSH_RD;
                end
            end
            S_POP_RDL: begin
                h1_d    = rd_data_s;
                state_d = S_POP_RDR;
            end
            S_POP_RDR: begin
                h2_d    = rd_data_s;
                state_d = S_POP_CMP;
            end
            S_POP_CMP: begin
                wr_en_s = 1'b1;
                if (have_child_s && (key_of(child_s) < key_of(h0_q))) begin
                    wr_data_s = child_s;
                    posn_d    = child_idx_s;
                    state_d   = S_POP_RDL;
                end else begin
                    wr_data_s = h0_q;
                    state_d   = S_IDLE;
                end
            end
`ifdef HEAP_CHECK_EN
            S_CHK_RD: begin
                if (posn_q >= count_ext_s) begin
                    state_d = S_IDLE;
                end else begin
                    h1_d    = rd_data_s;
                    state_d = S_CHK_CMP;
                end
            end
            S_CHK_CMP: begin
                if (key_of(rd_data_s) < key_of(h1_q)) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    posn_d  = posn_q + IDX_ONE;
                    state_d = S_CHK_RD;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State registers and heap storage with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            count_q  <= {(DEPTH_LOG+1){1'b0}};
            posn_q   <= {IW{1'b0}};
            h0_q     <= {EW{1'b0}};
            h1_q     <= {EW{1'b0}};
            h2_q     <= {EW{1'b0}};
            reject_q <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                h_q[i] <= {EW{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            posn_q   <= posn_d;
            h0_q     <= h0_d;
            h1_q     <= h1_d;
            h2_q     <= h2_d;
            reject_q <= reject_d;
            if (wr_en_s) begin
                h_q[wr_addr_s] <= wr_data_s;
            end
        end
    end

`ifdef HEAP_CHECK_EN
    // Sticky heap-violation flag.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end
    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.ready    = (state_q == S_IDLE);
    assign bus.full     = (count_q == FULL_CNT);
    assign bus.empty    = (count_q == {(DEPTH_LOG+1){1'b0}});
    assign bus.count    = count_q;
    assign bus.reject   = reject_q;
    assign bus.dout     = bus.empty ? {KEY_BITS{1'b0}} : key_of(h_q[0]);
    assign bus.dout_tag = bus.empty ? {TAG_BITS{1'b0}} : h_q[0][TAG_BITS-1:0];
endmodule

// File: tb/tb_prio_heap.sv
// -----------------------------------------------------------------------------
// tb_prio_heap : directed self-checking bench for prio_heap (defaults
// KEY_BITS=4, TAG_BITS=4, DEPTH_LOG=3). Inputs change and outputs are
// sampled on the falling clock edge. The randomized scan section is only
// built when HEAP_CHECK_EN is defined.
// -----------------------------------------------------------------------------
module tb_prio_heap;
    localparam int KB = 4;
    localparam int TB = 4;
    localparam int DL = 3;
    localparam logic [1:0] NOOP = 2'd0, PUSH = 2'd1, POP = 2'd2, REPL = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   lat;
    logic rej_seen;

    prio_heap_if #(.KEY_BITS(KB), .TAG_BITS(TB), .DEPTH_LOG(DL)) bus ();

    prio_heap #(.KEY_BITS(KB), .TAG_BITS(TB), .DEPTH_LOG(DL)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a falling edge; leaves at a falling edge with reset released.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present a command for one edge, then wait (bounded) for ready.
    // lat = number of sampled cycles with ready low.
    task automatic issue(input logic [1:0] c, input logic [3:0] k, input logic [3:0] t);
        bus.cmd = c; bus.din = k; bus.din_tag = t;
        @(negedge clk);
        bus.cmd = NOOP;
        rej_seen = bus.reject;
        lat = 0;
        while (bus.ready !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) chk("ready_timeout", bus.ready, 1);
    endtask

`ifdef HEAP_CHECK_EN
    int q[$];
    function automatic int qmin_idx();
        int m = 0;
        for (int i = 1; i < q.size(); i++) if (q[i] < q[m]) m = i;
        return m;
    endfunction

    task automatic run_check();
        bus.check = 1'b1;
        @(negedge clk);
        bus.check = 1'b0;
        lat = 0;
        while (bus.ready !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) chk("chk_timeout", bus.ready, 1);
    endtask
`endif

    initial begin
        bus.cmd = NOOP; bus.din = 4'd0; bus.din_tag = 4'd0; bus.check = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_ready", bus.ready, 1);
        chk("rst_dout", bus.dout, 0);
        chk("rst_reject", bus.reject, 0);
        chk("rst_error", bus.error, 0);

        // 1: PUSH 5,3,7,3 then drain
        issue(PUSH, 4'd5, 4'd1); chk("t1_lat_p5", lat, 2);
        issue(PUSH, 4'd3, 4'd2); chk("t1_lat_p3", lat, 4);
        issue(PUSH, 4'd7, 4'd3); chk("t1_lat_p7", lat, 2);
        issue(PUSH, 4'd3, 4'd4); chk("t1_lat_p3b", lat, 4);
        chk("t1_count", bus.count, 4);
        chk("t1_dout", bus.dout, 3);
        chk("t1_tag", bus.dout_tag, 2);
        issue(POP, 4'd0, 4'd0); chk("t1_lat_pop1", lat, 6);
        chk("t1_dout2", bus.dout, 3);
        chk("t1_tag2", bus.dout_tag, 4);
        issue(POP, 4'd0, 4'd0); chk("t1_lat_pop2", lat, 6);
        chk("t1_dout3", bus.dout, 5);
        chk("t1_tag3", bus.dout_tag, 1);
        issue(POP, 4'd0, 4'd0); chk("t1_lat_pop3", lat, 3);
        chk("t1_dout4", bus.dout, 7);
        chk("t1_tag4", bus.dout_tag, 3);
        issue(POP, 4'd0, 4'd0); chk("t1_lat_pop4", lat, 3);
        chk("t1_empty", bus.empty, 1);
        chk("t1_dout_empty", bus.dout, 0);
        chk("t1_count_empty", bus.count, 0);

        // 2: PUSH into empty heap
        do_reset();
        issue(PUSH, 4'd9, 4'd6);
        chk("t2_lat", lat, 2);
        chk("t2_dout", bus.dout, 9);
        chk("t2_tag", bus.dout_tag, 6);
        chk("t2_count", bus.count, 1);

        // 3: fill with 7..0, then PUSH when full
        do_reset();
        for (int k = 7; k >= 0; k--) issue(PUSH, 4'(k), 4'(15 - k));
        chk("t3_count", bus.count, 8);
        chk("t3_full", bus.full, 1);
        chk("t3_dout", bus.dout, 0);
        chk("t3_tag", bus.dout_tag, 15);
        issue(PUSH, 4'd9, 4'd9);
        chk("t3_reject", rej_seen, 1);
        chk("t3_ready_lat", lat, 0);
        chk("t3_ready", bus.ready, 1);
        chk("t3_count2", bus.count, 8);
        chk("t3_dout2", bus.dout, 0);
        @(negedge clk);
        chk("t3_reject_pulse", bus.reject, 0);

        // 4: REPLACE on {1,4,6}
        do_reset();
        issue(REPL, 4'd2, 4'd2);
        chk("t4_repl_empty_rej", rej_seen, 1);
        issue(PUSH, 4'd1, 4'd1);
        issue(PUSH, 4'd4, 4'd4);
        issue(PUSH, 4'd6, 4'd6);
        chk("t4_old_min", bus.dout, 1);
        issue(REPL, 4'd15, 4'd9);
        chk("t4_repl_lat", lat, 6);
        chk("t4_repl_rej", rej_seen, 0);
        chk("t4_count", bus.count, 3);
        chk("t4_dout", bus.dout, 4);
        chk("t4_tag", bus.dout_tag, 4);
        issue(POP, 4'd0, 4'd0); chk("t4_pop_lat", lat, 3);
        chk("t4_dout2", bus.dout, 6);
        issue(POP, 4'd0, 4'd0);
        chk("t4_dout3", bus.dout, 15);
        chk("t4_tag3", bus.dout_tag, 9);
        issue(POP, 4'd0, 4'd0);
        chk("t4_empty", bus.empty, 1);
        issue(POP, 4'd0, 4'd0);
        chk("t4_pop_empty_rej", rej_seen, 1);
        chk("t4_pop_empty_count", bus.count, 0);

        // 5: reset during PUSH_CMP of the 5th PUSH
        do_reset();
        for (int k = 4; k >= 1; k--) issue(PUSH, 4'(k), 4'(k));
        bus.cmd = PUSH; bus.din = 4'd0; bus.din_tag = 4'd7;
        @(negedge clk);                 // now in PUSH_RD
        bus.cmd = NOOP;
        @(negedge clk);                 // now in PUSH_CMP
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_count", bus.count, 0);
        chk("t5_empty", bus.empty, 1);
        chk("t5_ready", bus.ready, 1);
        chk("t5_dout", bus.dout, 0);
        chk("t5_reject", bus.reject, 0);
        issue(PUSH, 4'd6, 4'd3);
        chk("t5_after_dout", bus.dout, 6);
        chk("t5_after_count", bus.count, 1);

`ifdef HEAP_CHECK_EN
        // 6: random legal traffic against a multiset model, then scans
        do_reset();
        q.delete();
        for (int n = 0; n < 1000; n++) begin
            logic [1:0] c;
            logic [3:0] k;
            int mi;
            k = 4'($urandom_range(0, 15));
            if (q.size() == 0) c = PUSH;
            else if (q.size() == 8) c = 2'($urandom_range(2, 3));
            else c = 2'($urandom_range(1, 3));
            if (q.size() > 0) chk("t6_dout", bus.dout, q[qmin_idx()]);
            issue(c, k, 4'd0);
            if (c != PUSH) begin
                mi = qmin_idx();
                q.delete(mi);
            end
            if (c != POP) q.push_back(int'(k));
            chk("t6_count", bus.count, q.size());
        end
        while (q.size() < 4) begin
            issue(PUSH, 4'd8, 4'd0);
            q.push_back(8);
        end
        run_check();
        chk("t6_chk_lat", lat, 2 * (q.size() - 1) + 1);
        chk("t6_error_clean", bus.error, 0);
        dut.h_q[1] = 8'hF0;
        dut.h_q[3] = 8'h00;
        run_check();
        chk("t6_error_set", bus.error, 1);
        @(negedge clk);
        chk("t6_error_sticky", bus.error, 1);
`else
        // Without the scan feature, check is ignored and error stays low.
        bus.check = 1'b1;
        @(negedge clk);
        bus.check = 1'b0;
        chk("nochk_ready", bus.ready, 1);
        chk("nochk_error", bus.error, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
